// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that picks one completed functional-unit result per cycle
// and broadcasts it on the common data bus through a single register stage.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [1:0]                cdb_src
);

    // Requester indices and the pointer are 2 bits wide, so NUM_REQ may not exceed 4.
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [1:0]        cdb_src_q, cdb_src_d;

    logic              found;
    logic              grant_ok;
    logic [1:0]        sel;
    logic [2:0]        cand;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;

    // Scan the requesters starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        sel   = 2'd0;
        cand  = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!found && req_valid[cand[1:0]]) begin
                found = 1'b1;
                sel   = cand[1:0];
            end
        end
    end

    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (2'(i) == sel) begin
                sel_tag  = req_tag[i*TAG_W +: TAG_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset and flush both suppress the grant so no requester is consumed.
    always_comb begin
        grant_ok  = found && !flush && !rst;
        req_ready = '0;
        if (grant_ok) begin
            req_ready[sel] = 1'b1;
        end

        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_ok;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (grant_ok) begin
            cdb_tag_d  = sel_tag;
            cdb_data_d = sel_data;
            cdb_src_d  = sel;
            if ({1'b0, sel} == 3'(NUM_REQ - 1)) begin
                rr_ptr_d = 2'd0;
            end else begin
                rr_ptr_d = sel + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= 2'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter followed by a short randomized run
// against a small round-robin reference model.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  req_valid;
    logic [23:0] req_tag;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;

    logic [5:0]  tagArr [4];
    logic [31:0] dataArr [4];

    int compareCount;
    int mismatchCount;

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(6), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_tag[i*6 +: 6]    = tagArr[i];
            req_data[i*32 +: 32] = dataArr[i];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; combinational ready is sampled 1 ns later.
    task automatic applyStimulus(input logic r, input logic f, input logic [3:0] v);
        @(negedge clk);
        rst       = r;
        flush     = f;
        req_valid = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBus(input string name, input logic v, input logic [5:0] t,
                            input logic [31:0] d, input logic [1:0] s);
        checkOutput({name, ".valid"}, 64'(cdb_valid), 64'(v));
        checkOutput({name, ".tag"},   64'(cdb_tag),   64'(t));
        checkOutput({name, ".data"},  64'(cdb_data),  64'(d));
        checkOutput({name, ".src"},   64'(cdb_src),   64'(s));
    endtask

    logic [3:0]  pending;
    int          waitCnt [4];
    int          modelPtr;
    int          expGrant;
    logic        expXfer;
    logic        flushV;
    logic [5:0]  nextTag;
    logic [3:0]  expReady;

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b0000;
        tagArr[0] = 6'h10;  dataArr[0] = 32'hA000_0000;
        tagArr[1] = 6'h11;  dataArr[1] = 32'hA000_0001;
        tagArr[2] = 6'h15;  dataArr[2] = 32'hDEAD_BEEF;
        tagArr[3] = 6'h13;  dataArr[3] = 32'hA000_0003;

        // Reset holds ready low even with every requester valid.
        applyStimulus(1'b1, 1'b0, 4'b1111);
        checkOutput("rst.ready", 64'(req_ready), 64'h0);
        tick();
        checkBus("rst.bus", 1'b0, 6'h00, 32'h0, 2'd0);
        applyStimulus(1'b1, 1'b0, 4'b1111);
        tick();

        // Single requester 2 after reset.
        applyStimulus(1'b0, 1'b0, 4'b0100);
        checkOutput("single.ready", 64'(req_ready), 64'b0100);
        tick();
        checkBus("single.bus", 1'b1, 6'h15, 32'hDEAD_BEEF, 2'd2);

        // Pointer is now 3: grant 3, wrap to 0, grant 0.
        applyStimulus(1'b0, 1'b0, 4'b1001);
        checkOutput("wrap.ready3", 64'(req_ready), 64'b1000);
        tick();
        checkBus("wrap.bus3", 1'b1, 6'h13, 32'hA000_0003, 2'd3);
        applyStimulus(1'b0, 1'b0, 4'b1001);
        checkOutput("wrap.ready0", 64'(req_ready), 64'b0001);
        tick();
        checkBus("wrap.bus0", 1'b1, 6'h10, 32'hA000_0000, 2'd0);

        // Idle cycle: valid drops, payload holds.
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("idle.ready", 64'(req_ready), 64'h0);
        tick();
        checkBus("idle.bus", 1'b0, 6'h10, 32'hA000_0000, 2'd0);

        // Back to pointer 0, then all four valid for eight cycles.
        applyStimulus(1'b1, 1'b0, 4'b1111);
        tick();
        checkBus("rst2.bus", 1'b0, 6'h00, 32'h0, 2'd0);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, 4'b1111);
            checkOutput("rr.ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            tick();
            checkBus("rr.bus", 1'b1, tagArr[c % 4], dataArr[c % 4], 2'(c % 4));
        end

        // Flush: no grant, earlier broadcast still visible, pointer unchanged.
        applyStimulus(1'b0, 1'b0, 4'b0011);
        checkOutput("preflush.ready", 64'(req_ready), 64'b0001);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b1111);
        checkOutput("flush.ready", 64'(req_ready), 64'h0);
        checkBus("flush.visible", 1'b1, 6'h10, 32'hA000_0000, 2'd0);
        tick();
        checkBus("flush.after", 1'b0, 6'h10, 32'hA000_0000, 2'd0);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("resume.ready", 64'(req_ready), 64'b0010);
        tick();
        checkBus("resume.bus", 1'b1, 6'h11, 32'hA000_0001, 2'd1);

        // Reset with requester 1 waiting and a broadcast on the bus.
        applyStimulus(1'b1, 1'b0, 4'b0010);
        checkOutput("rst3.ready", 64'(req_ready), 64'h0);
        tick();
        checkBus("rst3.bus", 1'b0, 6'h00, 32'h0, 2'd0);
        applyStimulus(1'b0, 1'b0, 4'b0010);
        checkOutput("postrst.ready", 64'(req_ready), 64'b0010);
        tick();
        checkBus("postrst.bus", 1'b1, 6'h11, 32'hA000_0001, 2'd1);
        applyStimulus(1'b0, 1'b0, 4'b0111);
        checkOutput("ptr2.ready", 64'(req_ready), 64'b0100);
        tick();
        checkBus("ptr2.bus", 1'b1, 6'h15, 32'hDEAD_BEEF, 2'd2);

        // Randomized traffic; requesters hold their payload until granted.
        modelPtr = 3;
        pending  = 4'b0000;
        nextTag  = 6'h20;
        for (int i = 0; i < 4; i++) waitCnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
                    pending[i] = 1'b1;
                    tagArr[i]  = nextTag;
                    dataArr[i] = $urandom;
                    nextTag    = nextTag + 6'd1;
                    waitCnt[i] = 0;
                end
            end
            flushV    = ($urandom_range(0, 15) == 0);
            rst       = 1'b0;
            flush     = flushV;
            req_valid = pending;
            #1;
            expGrant = -1;
            if (!flushV) begin
                for (int k = 0; k < 4; k++) begin
                    if (expGrant < 0 && pending[(modelPtr + k) % 4]) begin
                        expGrant = (modelPtr + k) % 4;
                    end
                end
            end
            expXfer  = (expGrant >= 0);
            expReady = expXfer ? (4'b0001 << expGrant) : 4'b0000;
            checkOutput("rand.ready", 64'(req_ready), 64'(expReady));
            tick();
            checkOutput("rand.valid", 64'(cdb_valid), 64'(expXfer));
            if (expXfer) begin
                checkOutput("rand.tag",  64'(cdb_tag),  64'(tagArr[expGrant]));
                checkOutput("rand.data", 64'(cdb_data), 64'(dataArr[expGrant]));
                checkOutput("rand.src",  64'(cdb_src),  64'(expGrant));
                checkOutput("rand.wait", 64'(waitCnt[expGrant] <= 3), 64'd1);
                pending[expGrant] = 1'b0;
                modelPtr = (expGrant + 1) % 4;
            end
            if (!flushV) begin
                for (int i = 0; i < 4; i++) begin
                    if (pending[i]) waitCnt[i]++;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
